spy_serial_tx: RTL and testbench



---
 rtl/spy_serial_tx_pkg.sv | 21 ++
 rtl/spy_bit_timer.sv | 32 +++
 rtl/spy_serial_tx.sv | 124 ++++++++++++
 tb/tb_spy_serial_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spy_serial_tx_pkg.sv
// Shared definitions for the spy serial link: frame state encoding, line levels
// and the default bit period used by both the transmitter and the receiver.
package spy_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE       = 1'b1;
  localparam int   SPY_DEFAULT_DIV = 16;

  // Odd parity over a zero-extended word; the extension bits do not change the XOR.
  function automatic logic odd_parity(input logic [31:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/spy_bit_timer.sv
// DIV-modulus bit-period counter with synchronous clear. Pulses o_bit_end on the
// last clock of each bit and o_near_end on the clock before it.
module spy_bit_timer
  import spy_serial_tx_pkg::*;
#(
  parameter int DIV = SPY_DEFAULT_DIV
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_run,
  output logic o_near_end,
  output logic o_bit_end
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PREV = CW'(DIV - 2);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_bit_end  = i_run && (r_count == LAST);
  assign o_near_end = i_run && (r_count == PREV);

endmodule

// File: rtl/spy_serial_tx.sv
// Spy link transmitter: start bit, WIDTH data bits LSB-first, optional odd parity,
// stop bit. Handshake: a word transfers on any CLK edge where LOAD and READY are both high.
module spy_serial_tx
  import spy_serial_tx_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIV    = SPY_DEFAULT_DIV,
  parameter int PARITY = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD,
  output logic             READY,
  output logic             BUSY,
  output logic             TXD
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic             r_par;
  logic             r_ready;
  logic             r_busy;
  logic             r_txd;

  logic             w_accept;
  logic             w_bit_end;
  logic             w_near_end;
  logic [WIDTH-1:0] w_shift_next;

  assign w_accept     = LOAD && r_ready && !CLR;
  assign w_shift_next = r_shift >> 1;

  spy_bit_timer #(.DIV(DIV)) u_timer (
    .i_clk      (CLK),
    .i_clr      (CLR || w_accept),
    .i_run      (r_state != ST_IDLE),
    .o_near_end (w_near_end),
    .o_bit_end  (w_bit_end)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_txd    <= LINE_IDLE;
    end else if (w_accept) begin
      // Reached from IDLE or from the final stop clock, so back-to-back frames have no gap.
      r_state  <= ST_START;
      r_shift  <= DATA;
      r_par    <= odd_parity(32'(DATA));
      r_bitcnt <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_txd    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_txd   <= LINE_IDLE;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_txd   <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= w_shift_next;
            if (r_bitcnt == LAST_BIT) begin
              r_bitcnt <= '0;
              if (PARITY != 0) begin
                r_state <= ST_PAR;
                r_txd   <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_txd   <= LINE_IDLE;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_txd    <= w_shift_next[0];
            end
          end
        end
        ST_PAR: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_txd   <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (w_near_end) begin
            r_ready <= 1'b1;
          end
          if (w_bit_end) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_txd   <= LINE_IDLE;
        end
      endcase
    end
  end

  assign READY = r_ready;
  assign BUSY  = r_busy;
  assign TXD   = r_txd;

endmodule

// File: tb/tb_spy_serial_tx.sv
// Bench for spy_serial_tx: a parity instance and a no-parity instance, each checked
// every cycle against a queue of expected line levels, plus literal frame captures.
module tb_spy_serial_tx;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       clr_p, load_p, ready_p, busy_p, txd_p;
  logic [7:0] data_p;
  logic       clr_n, load_n, ready_n, busy_n, txd_n;
  logic [7:0] data_n;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [0:0] exp_q_p[$];
  logic [0:0] exp_q_n[$];

  always #5 clk = ~clk;

  spy_serial_tx #(.WIDTH(8), .DIV(D), .PARITY(1)) dut_p (
    .CLK(clk), .CLR(clr_p), .DATA(data_p), .LOAD(load_p),
    .READY(ready_p), .BUSY(busy_p), .TXD(txd_p)
  );

  spy_serial_tx #(.WIDTH(8), .DIV(D), .PARITY(0)) dut_n (
    .CLK(clk), .CLR(clr_n), .DATA(data_n), .LOAD(load_n),
    .READY(ready_n), .BUSY(busy_n), .TXD(txd_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list: index 0 start, 1..8 data LSB first, then parity/stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
    if (par) begin
      f[9]  = ~(^d);
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  // Model: the queue holds the line level for each upcoming clock of the frame.
  logic [10:0] f_p, f_n;
  bit          acc_p, acc_n;

  always @(posedge clk) begin
    if (clr_p) begin
      exp_q_p.delete();
    end else begin
      acc_p = load_p && (exp_q_p.size() <= 1);
      if (exp_q_p.size() > 0) void'(exp_q_p.pop_front());
      if (acc_p) begin
        f_p = frame_bits(data_p, 1'b1);
        for (int b = 0; b < 11; b++)
          for (int k = 0; k < D; k++) exp_q_p.push_back(f_p[b]);
      end
    end
    if (clr_n) begin
      exp_q_n.delete();
    end else begin
      acc_n = load_n && (exp_q_n.size() <= 1);
      if (exp_q_n.size() > 0) void'(exp_q_n.pop_front());
      if (acc_n) begin
        f_n = frame_bits(data_n, 1'b0);
        for (int b = 0; b < 10; b++)
          for (int k = 0; k < D; k++) exp_q_n.push_back(f_n[b]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("p_txd",   32'(txd_p),   32'((exp_q_p.size() > 0) ? exp_q_p[0] : 1'b1));
      chk("p_ready", 32'(ready_p), 32'(exp_q_p.size() <= 1));
      chk("p_busy",  32'(busy_p),  32'(exp_q_p.size() > 0));
      chk("n_txd",   32'(txd_n),   32'((exp_q_n.size() > 0) ? exp_q_n[0] : 1'b1));
      chk("n_ready", 32'(ready_n), 32'(exp_q_n.size() <= 1));
      chk("n_busy",  32'(busy_n),  32'(exp_q_n.size() > 0));
    end
  end

  task automatic run_p(input logic [7:0] d1, input logic [7:0] d2, input bit hold,
                       input int inj_load_c, input int inj_clr_c,
                       output logic [21:0] bits, output int busy_len);
    bits     = '0;
    busy_len = 0;
    @(negedge clk);
    data_p = d1;
    load_p = 1'b1;
    @(negedge clk);
    if (hold) data_p = d2;
    else load_p = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy_p) break;
      if ((c % D) == 1 && (c / D) < 22) bits[c / D] = txd_p;
      busy_len++;
      if (inj_load_c >= 0 && c == inj_load_c) begin
        data_p = 8'hFF;
        load_p = 1'b1;
      end else if (inj_load_c >= 0 && c == inj_load_c + 1) begin
        load_p = 1'b0;
      end
      if (hold && c == 50) load_p = 1'b0;
      if (c == inj_clr_c) clr_p = 1'b1;
      @(negedge clk);
    end
    clr_p  = 1'b0;
    load_p = 1'b0;
  endtask

  task automatic run_n(input logic [7:0] d, output logic [9:0] bits, output int busy_len);
    bits     = '0;
    busy_len = 0;
    @(negedge clk);
    data_n = d;
    load_n = 1'b1;
    @(negedge clk);
    load_n = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy_n) break;
      if ((c % D) == 1 && (c / D) < 10) bits[c / D] = txd_n;
      busy_len++;
      @(negedge clk);
    end
  endtask

  task automatic idle_p(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy_p || !txd_p) bad++;
    end
  endtask

  logic [21:0] bits;
  logic [9:0]  bits_n;
  int          len;
  int          bad;

  initial begin
    clr_p = 1'b1; load_p = 1'b0; data_p = '0;
    clr_n = 1'b1; load_n = 1'b0; data_n = '0;
    repeat (2) @(negedge clk);
    chk("rst_p_txd",   32'(txd_p),   32'd1);
    chk("rst_p_ready", 32'(ready_p), 32'd1);
    chk("rst_p_busy",  32'(busy_p),  32'd0);
    chk("rst_n_txd",   32'(txd_n),   32'd1);
    chk("rst_n_ready", 32'(ready_n), 32'd1);
    chk("rst_n_busy",  32'(busy_n),  32'd0);
    clr_p  = 1'b0;
    clr_n  = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    run_p(8'hA5, 8'h00, 1'b0, -1, -1, bits, len);
    chk("a5_bits", 32'(bits[10:0]), 32'(11'b11101001010));
    chk("a5_busy_len", len, 44);

    run_p(8'h01, 8'h00, 1'b0, -1, -1, bits, len);
    chk("01_bits", 32'(bits[10:0]), 32'(11'b10000000010));
    chk("01_busy_len", len, 44);

    run_p(8'h3C, 8'hC3, 1'b1, -1, -1, bits, len);
    chk("b2b_first_bits",  32'(bits[10:0]),  32'(11'b11001111000));
    chk("b2b_second_bits", 32'(bits[21:11]), 32'(11'b11110000110));
    chk("b2b_busy_len", len, 88);
    idle_p(20, bad);
    chk("b2b_no_third_frame", bad, 0);

    run_p(8'h55, 8'h00, 1'b0, 15, -1, bits, len);
    chk("ign_bits", 32'(bits[10:0]), 32'(11'b11010101010));
    chk("ign_busy_len", len, 44);
    idle_p(20, bad);
    chk("ign_no_extra_frame", bad, 0);

    run_p(8'h0F, 8'h00, 1'b0, -1, 17, bits, len);
    chk("clr_partial_bits", 32'(bits[4:0]), 32'(5'b11110));
    chk("clr_busy_len", len, 18);
    chk("clr_txd",   32'(txd_p),   32'd1);
    chk("clr_ready", 32'(ready_p), 32'd1);
    chk("clr_busy",  32'(busy_p),  32'd0);
    repeat (2) @(negedge clk);
    run_p(8'h81, 8'h00, 1'b0, -1, -1, bits, len);
    chk("81_bits", 32'(bits[10:0]), 32'(11'b11100000010));
    chk("81_busy_len", len, 44);

    @(negedge clk);
    clr_p  = 1'b1;
    load_p = 1'b1;
    data_p = 8'h5A;
    @(negedge clk);
    clr_p  = 1'b0;
    load_p = 1'b0;
    chk("prio_ready", 32'(ready_p), 32'd1);
    idle_p(2 * D + 4, bad);
    chk("prio_no_frame", bad, 0);

    run_n(8'h00, bits_n, len);
    chk("np_00_bits", 32'(bits_n), 32'(10'b1000000000));
    chk("np_00_busy_len", len, 40);
    run_n(8'h96, bits_n, len);
    chk("np_96_bits", 32'(bits_n), 32'(10'b1100101100));
    chk("np_96_busy_len", len, 40);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
